// File: rtl/clink_act_lut.sv
// clink_act_lut: sigmoid/tanh activation from a loadable sigmoid table, rebuilt by symmetry and saturation.
module clink_act_lut #(
    parameter int LUT_SIZE = 1024,
    parameter int ADDR_W   = 10,
    parameter int ONE      = 4096
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              lut_we,
    input  logic [ADDR_W-1:0] lut_addr,
    input  logic [15:0]       lut_wdata,
    input  logic [ADDR_W-1:0] idx_in,
    input  logic [1:0]        sel_in,
    input  logic              is_tanh,
    input  logic              in_valid,
    output logic [15:0]       act_out,
    output logic              out_valid
);
    localparam logic signed [17:0] ONE_S = 18'(ONE);

    logic [15:0]       table_mem [LUT_SIZE];
    logic [ADDR_W-1:0] idx_d;
    logic [15:0]       lut_q;
    logic [1:0]        sel_q;
    logic              tanh_q;
    logic              v1;
    logic signed [17:0] l, l2, res, clamped;

    // Table storage is deliberately left out of reset so it survives a mid-stream reset.
    always_ff @(posedge clock)
        if (lut_we) table_mem[lut_addr] <= lut_wdata;

    always_comb begin
        l       = {2'b00, lut_q};
        l2      = l <<< 1;
        res     = sel_q == 2'd0 ? ONE_S :
                  sel_q == 2'd1 ? (tanh_q ? l2 - ONE_S : l) :
                  sel_q == 2'd2 ? (tanh_q ? ONE_S - l2 : ONE_S - l) :
                                  (tanh_q ? -ONE_S : 18'sd0);
        clamped = res > ONE_S ? ONE_S : res < -ONE_S ? -ONE_S : res;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_d     <= '0;
            lut_q     <= '0;
            sel_q     <= '0;
            tanh_q    <= 1'b0;
            v1        <= 1'b0;
            act_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            idx_d     <= idx_in;
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) begin
                lut_q  <= table_mem[idx_d];
                sel_q  <= sel_in;
                tanh_q <= is_tanh;
            end
            if (v1) act_out <= clamped[15:0];
        end
    end
endmodule

// File: tb/tb_clink_act_lut.sv
// tb_clink_act_lut: randomized scoreboard bench for clink_act_lut with directed corner cases.
module tb_clink_act_lut;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        lut_we = 1'b0;
    logic [9:0]  lut_addr = '0;
    logic [15:0] lut_wdata = '0;
    logic [9:0]  idx_in = '0;
    logic [1:0]  sel_in = '0;
    logic        is_tanh = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] act_out;
    logic        out_valid;

    typedef struct {
        logic [15:0] v;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          tbl[1024];
    int          prev_idx = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [15:0] last_out = '0;

    clink_act_lut dut (
        .clock(clock), .reset_n(reset_n), .lut_we(lut_we), .lut_addr(lut_addr),
        .lut_wdata(lut_wdata), .idx_in(idx_in), .sel_in(sel_in), .is_tanh(is_tanh),
        .in_valid(in_valid), .act_out(act_out), .out_valid(out_valid)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference: sigmoid(|x|) sample L, mirrored for negative side, tanh = 2*sigmoid - 1, clamp to +-1.0.
    function automatic logic [15:0] ref_act(input int l, input int sel, input bit t);
        int sig, v;
        sig = sel == 0 ? 4096 : sel == 1 ? l : sel == 2 ? 4096 - l : 0;
        v = t ? 2 * sig - 4096 : sig;
        if (v > 4096) v = 4096;
        if (v < -4096) v = -4096;
        return 16'(v);
    endfunction

    task automatic step(input int idx, input int sel, input bit t, input bit v, input int exp,
                        input bit we = 1'b0, input int wa = 0, input int wd = 0);
        exp_t e;
        @(negedge clock);
        idx_in = idx[9:0]; sel_in = sel[1:0]; is_tanh = t; in_valid = v;
        lut_we = we; lut_addr = wa[9:0]; lut_wdata = wd[15:0];
        if (v) begin
            e.v = exp < 0 ? ref_act(tbl[prev_idx], sel, t) : 16'(exp);
            e.due = cyc + 2;
            q.push_back(e);
        end
        if (we) tbl[wa] = wd;
        prev_idx = idx;
    endtask

    task automatic check_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || act_out !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: act_out=%h out_valid=%b required act_out=0000 out_valid=0", act_out, out_valid);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (reset_n) begin
                total++;
                if (out_valid) begin
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_out: act_out=%h at cycle %0d, nothing expected", act_out, cyc);
                    end else begin
                        e = q.pop_front();
                        if (act_out !== e.v || cyc != e.due) begin
                            bad++;
                            $display("FAIL act_out: got %h at cycle %0d, required %h at cycle %0d", act_out, cyc, e.v, e.due);
                        end
                    end
                    last_out = act_out;
                end else begin
                    if (act_out !== last_out) begin
                        bad++;
                        $display("FAIL hold: act_out=%h required %h", act_out, last_out);
                    end
                    if (q.size() != 0 && q[0].due <= cyc) begin
                        e = q.pop_front();
                        bad++;
                        $display("FAIL missing_out: none at cycle %0d, required %h due %0d", cyc, e.v, e.due);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        check_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 1024; i++)
            step(0, 0, 0, 0, -1, 1, i, $urandom_range(0, 6000));
        step(0, 0, 0, 0, -1, 1, 5, 2304);
        step(0, 0, 0, 0, -1, 1, 7, 5000);
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, -1, 1, i, 100 * i);
        step(0, 0, 0, 0, -1, 1, 10, 1010);
        step(0, 0, 0, 0, -1, 1, 20, 2020);
        step(0, 0, 0, 0, -1, 1, 30, 3030);
        // Basic lookups on entry 5
        step(5, 0, 0, 0, -1);
        step(5, 1, 0, 1, 2304);
        step(5, 2, 0, 1, 1792);
        step(5, 1, 1, 1, 512);
        step(3, 2, 1, 1, 'hFE00);
        // Saturation regions
        step(3, 0, 0, 1, 'h1000);
        step(3, 0, 1, 1, 'h1000);
        step(7, 3, 0, 1, 'h0000);
        step(7, 3, 1, 1, 'hF000);
        step(1, 1, 1, 1, 'h1000);
        // Back-to-back stream, then a gap
        step(2, 1, 0, 1, 100);
        step(3, 1, 0, 1, 200);
        step(4, 1, 0, 1, 300);
        step(0, 1, 0, 1, 400);
        step(0, 1, 0, 0, -1);
        step(0, 1, 0, 0, -1);
        // Alignment: valid pairs with the idx of the previous cycle
        step(10, 0, 0, 0, -1);
        step(20, 0, 0, 0, -1);
        step(30, 1, 0, 1, 2020);
        step(5, 0, 0, 0, -1);
        step(5, 1, 0, 1, 2304);
        step(5, 1, 0, 1, 2304);
        // Reset with results in flight
        @(negedge clock);
        in_valid = 1'b0;
        reset_n = 1'b0;
        q.delete();
        last_out = '0;
        check_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) step(5, 0, 0, 0, -1);
        step(5, 1, 0, 1, 2304);
        // Same-cycle write/read returns old data, then the new data
        step(5, 1, 0, 1, 2304, 1, 5, 1111);
        step(5, 1, 0, 1, 1111);
        step(5, 1, 0, 0, -1);
        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1023), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 7, -1, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1023), $urandom_range(0, 6000));
        repeat (5) step(0, 0, 0, 0, -1);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
